// File: rtl/q2_panel_debounce.sv
// q2_panel_debounce: synchronises and debounces the q2 front-panel switches,
// turning momentary presses into single active-low pulses with INC-P auto-repeat.
module q2_panel_debounce_chan #(
  parameter int DB  = 20000,
  parameter int RD  = 500000,
  parameter int RR  = 100000,
  parameter int CW  = 20,
  parameter bit REP = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic lvl,
  output logic fire
);
  typedef enum logic [2:0] {DISARMED, IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;
  localparam logic [CW-1:0] DB_END    = CW'(DB - 1);
  localparam logic [CW-1:0] RD_END    = CW'(RD - 1);
  localparam logic [CW-1:0] RD_RELOAD = CW'(RD - RR);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
  logic first, rep;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= DISARMED;
      cnt   <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rcnt  <= rcnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    first    = 1'b0;
    case (state)
      DISARMED:   if (!lvl) cnt_nx = '0;
                  else if (cnt == DB_END) state_nx = IDLE;
                  else cnt_nx = cnt + 1'b1;
      IDLE:       if (!lvl) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = '0;
                  end
      PRESS_WAIT: if (lvl) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                  end else if (cnt == DB_END) begin
                    state_nx = HELD;
                    first    = 1'b1;
                  end else cnt_nx = cnt + 1'b1;
      HELD:       if (lvl) begin
                    state_nx = REL_WAIT;
                    cnt_nx   = '0;
                  end
      REL_WAIT:   if (!lvl) state_nx = HELD;
                  else if (cnt == DB_END) state_nx = IDLE;
                  else cnt_nx = cnt + 1'b1;
      default:    state_nx = DISARMED;
    endcase
  end
  // repeat counter reloads so that every later repeat is RR cycles after the previous one
  assign rep     = REP && state == HELD && !lvl && rcnt == RD_END;
  assign rcnt_nx = (REP && state == HELD) ? (rep ? RD_RELOAD : rcnt + 1'b1) : '0;
  assign fire    = first || rep;
endmodule

module q2_panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter int CW              = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [11:0] nsw_raw,
  input  logic        nstart_raw,
  input  logic        nstop_raw,
  input  logic        ndep_raw,
  input  logic        nincp_raw,
  input  logic        run,
  output logic [11:0] nsw,
  output logic        nstart_sw,
  output logic        nstop_sw,
  output logic        ndep_sw,
  output logic        nincp_sw
);
  localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_CYCLES - 1);
  logic [15:0] sync1, sync2;
  logic [11:0] cand;
  logic [CW-1:0] dcnt;
  logic [3:0] fire;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {nincp_raw, ndep_raw, nstop_raw, nstart_raw, nsw_raw};
      sync2 <= sync1;
    end
  // the whole toggle group shares one counter so nsw only ever moves as a unit
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      cand <= '1;
      dcnt <= '0;
      nsw  <= '1;
    end else if (sync2[11:0] != cand) begin
      cand <= sync2[11:0];
      dcnt <= '0;
    end else if (dcnt == DB_END) nsw <= cand;
    else dcnt <= dcnt + 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_chan
    q2_panel_debounce_chan #(
      .DB(DEBOUNCE_CYCLES), .RD(REPEAT_DELAY), .RR(REPEAT_RATE), .CW(CW), .REP(i == 3)
    ) u_chan (
      .clk(clk), .nrst(nrst), .lvl(sync2[12+i]), .fire(fire[i])
    );
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      nstart_sw <= 1'b1;
      nstop_sw  <= 1'b1;
      ndep_sw   <= 1'b1;
      nincp_sw  <= 1'b1;
    end else begin
      nstart_sw <= !(fire[0] && !fire[1]);
      nstop_sw  <= !fire[1];
      ndep_sw   <= !(fire[2] && !run);
      nincp_sw  <= !(fire[3] && !fire[2] && !run);
    end
endmodule

// File: tb/tb_q2_panel_debounce.sv
// tb_q2_panel_debounce: directed panel scenarios plus randomized switch activity
// checked against a run-length hysteresis model of the panel conditioner.
module tb_q2_panel_debounce;
  localparam int DB = 4, RD = 10, RR = 3;
  logic clk = 1'b0, nrst = 1'b0, run = 1'b0;
  logic [11:0] nsw_raw = '1;
  logic nstart_raw = 1'b1, nstop_raw = 1'b1, ndep_raw = 1'b1, nincp_raw = 1'b1;
  logic [11:0] nsw;
  logic nstart_sw, nstop_sw, ndep_sw, nincp_sw;
  int checks = 0, errors = 0;

  q2_panel_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CW(8)) dut (
    .clk(clk), .nrst(nrst), .nsw_raw(nsw_raw), .nstart_raw(nstart_raw), .nstop_raw(nstop_raw),
    .ndep_raw(ndep_raw), .nincp_raw(nincp_raw), .run(run), .nsw(nsw), .nstart_sw(nstart_sw),
    .nstop_sw(nstop_sw), .ndep_sw(ndep_sw), .nincp_sw(nincp_sw)
  );

  always #5 clk = ~clk;

  // Reference: level seen by the debouncer is the raw input two edges late; a press is
  // accepted once a low run reaches DB+1 samples, released after a high run of DB+1,
  // and armed after reset once DB high samples are seen.
  logic [15:0] h1, h2, l;
  int run_len[4], st[4], hold_start[4], ecount, drun;
  logic prev[4];
  bit broken[4], ev[4];
  logic [11:0] dprev, exp_nsw;
  logic exp_nstart, exp_nstop, exp_ndep, exp_nincp;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h1 = '1; h2 = '1; ecount = 0; drun = 1; dprev = '1; exp_nsw = '1;
      {exp_nstart, exp_nstop, exp_ndep, exp_nincp} = 4'hF;
      for (int c = 0; c < 4; c++) begin
        run_len[c] = 0; st[c] = 0; prev[c] = 1'b1; broken[c] = 0; ev[c] = 0; hold_start[c] = 0;
      end
    end else begin
      ecount++;
      l = h2; h2 = h1; h1 = {nincp_raw, ndep_raw, nstop_raw, nstart_raw, nsw_raw};
      for (int c = 0; c < 4; c++) begin
        if (l[12+c] == prev[c]) run_len[c]++;
        else begin run_len[c] = 1; prev[c] = l[12+c]; end
        ev[c] = 0;
        if (st[c] == 0) begin
          if (l[12+c] && run_len[c] >= DB) st[c] = 1;
        end else if (st[c] == 1) begin
          if (!l[12+c] && run_len[c] == DB + 1) begin
            st[c] = 2; ev[c] = 1; hold_start[c] = ecount; broken[c] = 0;
          end
        end else if (l[12+c]) begin
          broken[c] = 1;
          if (run_len[c] >= DB + 1) st[c] = 1;
        end else if (broken[c]) begin
          hold_start[c] = ecount; broken[c] = 0;
        end else if (c == 3 && ecount - hold_start[c] >= RD && (ecount - hold_start[c] - RD) % RR == 0)
          ev[c] = 1;
      end
      exp_nstop  = !ev[1];
      exp_nstart = !(ev[0] && !ev[1]);
      exp_ndep   = !(ev[2] && !run);
      exp_nincp  = !(ev[3] && !ev[2] && !run);
      if (l[11:0] == dprev) drun++;
      else begin drun = 1; dprev = l[11:0]; end
      if (drun >= DB + 1) exp_nsw = l[11:0];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0; nstart_raw = 1'b0;
    tick(3);
    checks++;
    if ({nstart_sw, nstop_sw, ndep_sw, nincp_sw} !== 4'hF) begin
      errors++; $display("FAIL reset_pulses got %b want 1111", {nstart_sw, nstop_sw, ndep_sw, nincp_sw});
    end
    checks++;
    if (nsw !== 12'hFFF) begin errors++; $display("FAIL reset_nsw got %h want fff", nsw); end
    nstart_raw = 1'b1; nrst = 1'b1;
    tick(10);
    checks++;
    if ({nstart_sw, nstop_sw, ndep_sw, nincp_sw, nsw} !== 16'hFFFF) begin
      errors++; $display("FAIL idle_after_reset got %h want ffff", {nstart_sw, nstop_sw, ndep_sw, nincp_sw, nsw});
    end
  endtask

  task automatic test_start_clean();
    int first_at = 0, cnt = 0, others = 0;
    nstart_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (!nstart_sw) begin cnt++; if (first_at == 0) first_at = i; end
      if (!nstop_sw || !ndep_sw || !nincp_sw) others++;
    end
    nstart_raw = 1'b1; tick(10);
    checks++; if (first_at != 7) begin errors++; $display("FAIL start_latency got %0d want 7", first_at); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL start_pulses got %0d want 1", cnt); end
    checks++; if (others != 0) begin errors++; $display("FAIL start_other_pulses got %0d want 0", others); end
  endtask

  task automatic test_dep_bounce();
    int first_at = 0, cnt = 0;
    for (int i = 0; i < 22; i++) begin
      ndep_raw = (i < 12) ? logic'((i / 2) % 2) : 1'b0;
      tick(1);
      if (!ndep_sw) begin cnt++; if (first_at == 0) first_at = i + 1; end
    end
    ndep_raw = 1'b1; tick(10);
    checks++; if (cnt != 1) begin errors++; $display("FAIL dep_bounce_pulses got %0d want 1", cnt); end
    checks++; if (first_at != 19) begin errors++; $display("FAIL dep_bounce_edge got %0d want 19", first_at); end
  endtask

  task automatic test_incp_repeat();
    int exp_t[6] = '{7, 17, 20, 23, 26, 29};
    int got[$];
    nincp_raw = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (!nincp_sw) got.push_back(i);
    end
    nincp_raw = 1'b1; tick(15);
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL incp_count got %0d want 6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= got.size() || got[k] != exp_t[k]) begin
        errors++; $display("FAIL incp_edge%0d got %0d want %0d", k, (k < got.size()) ? got[k] : -1, exp_t[k]);
      end
    end
  endtask

  task automatic test_run_gating();
    int first_at = 0, cnt = 0;
    run = 1'b1; ndep_raw = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 9) run = 1'b0;
      tick(1);
      if (!ndep_sw) cnt++;
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL dep_gated_pulses got %0d want 0", cnt); end
    ndep_raw = 1'b1; tick(10);
    cnt = 0; ndep_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (!ndep_sw) begin cnt++; if (first_at == 0) first_at = i; end
    end
    ndep_raw = 1'b1; tick(10);
    checks++; if (cnt != 1) begin errors++; $display("FAIL dep_repress_pulses got %0d want 1", cnt); end
    checks++; if (first_at != 7) begin errors++; $display("FAIL dep_repress_edge got %0d want 7", first_at); end
  endtask

  task automatic test_priority();
    int n_start = 0, n_stop = 0, stop_at = 0, n_dep = 0, n_incp = 0, changes = 0, bad = 0;
    logic [11:0] last;
    nstart_raw = 1'b0; nstop_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (!nstart_sw) n_start++;
      if (!nstop_sw) begin n_stop++; if (stop_at == 0) stop_at = i; end
    end
    nstart_raw = 1'b1; nstop_raw = 1'b1; tick(10);
    checks++; if (n_start != 0) begin errors++; $display("FAIL prio_start_pulses got %0d want 0", n_start); end
    checks++; if (n_stop != 1) begin errors++; $display("FAIL prio_stop_pulses got %0d want 1", n_stop); end
    checks++; if (stop_at != 7) begin errors++; $display("FAIL prio_stop_edge got %0d want 7", stop_at); end
    ndep_raw = 1'b0; nincp_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (!ndep_sw) n_dep++;
      if (!nincp_sw) n_incp++;
    end
    ndep_raw = 1'b1; nincp_raw = 1'b1; tick(10);
    checks++; if (n_dep != 1) begin errors++; $display("FAIL prio_dep_pulses got %0d want 1", n_dep); end
    checks++; if (n_incp != 0) begin errors++; $display("FAIL prio_incp_pulses got %0d want 0", n_incp); end
    last = nsw;
    for (int i = 0; i < 23; i++) begin
      nsw_raw = (i == 1 || i == 2) ? 12'h5A7 : 12'h5A5;
      tick(1);
      if (nsw !== last) changes++;
      if (nsw !== 12'hFFF && nsw !== 12'h5A5) bad++;
      last = nsw;
    end
    checks++; if (changes != 1) begin errors++; $display("FAIL nsw_changes got %0d want 1", changes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL nsw_partial got %0d want 0", bad); end
    checks++; if (nsw !== 12'h5A5) begin errors++; $display("FAIL nsw_final got %h want 5a5", nsw); end
    nsw_raw = '1; tick(10);
  endtask

  task automatic test_reset_mid();
    int cnt = 0, first_at = 0;
    nstop_raw = 1'b0; tick(10);
    nrst = 1'b0; tick(2); nrst = 1'b1;
    for (int i = 1; i <= 15; i++) begin tick(1); if (!nstop_sw) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL stop_held_reset got %0d want 0", cnt); end
    nstop_raw = 1'b1; tick(10);
    cnt = 0; nstop_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (!nstop_sw) begin cnt++; if (first_at == 0) first_at = i; end
    end
    nstop_raw = 1'b1; tick(10);
    checks++; if (cnt != 1 || first_at != 7) begin
      errors++; $display("FAIL stop_repress got %0d@%0d want 1@7", cnt, first_at);
    end
    nstart_raw = 1'b0; tick(7);
    checks++; if (nstart_sw !== 1'b0) begin errors++; $display("FAIL start_before_abort got %b want 0", nstart_sw); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (nstart_sw !== 1'b1) begin errors++; $display("FAIL async_abort got %b want 1", nstart_sw); end
    nstart_raw = 1'b1; tick(2); nrst = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin tick(1); if (!nstart_sw) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL abort_late_pulse got %0d want 0", cnt); end
    nstart_raw = 1'b0; tick(4);
    #2 nrst = 1'b0;
    #1;
    checks++; if ({nstart_sw, nstop_sw, ndep_sw, nincp_sw} !== 4'hF) begin
      errors++; $display("FAIL pw_reset_outputs got %b want 1111", {nstart_sw, nstop_sw, ndep_sw, nincp_sw});
    end
    nstart_raw = 1'b1; tick(2); nrst = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin tick(1); if (!nstart_sw) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL pw_reset_pulse got %0d want 0", cnt); end
  endtask

  task automatic test_random();
    int cd[4] = '{0, 0, 0, 0};
    int dcd = 0, rcd = 0;
    logic [3:0] mom = 4'hF;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (cd[c] == 0) begin
          mom[c] = ~mom[c];
          cd[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
        end else cd[c]--;
      end
      {nincp_raw, ndep_raw, nstop_raw, nstart_raw} = mom;
      if (dcd == 0) begin
        nsw_raw = $urandom_range(0, 1) ? nsw_raw ^ (12'h1 << $urandom_range(0, 11)) : 12'($urandom);
        dcd = $urandom_range(1, 10);
      end else dcd--;
      if (rcd == 0) begin run = ~run; rcd = $urandom_range(1, 40); end else rcd--;
      nrst = ($urandom_range(0, 999) != 0);
      tick(1);
      checks++; if (nstart_sw !== exp_nstart) begin errors++; $display("FAIL rnd_start t=%0d got %b want %b", t, nstart_sw, exp_nstart); end
      checks++; if (nstop_sw !== exp_nstop) begin errors++; $display("FAIL rnd_stop t=%0d got %b want %b", t, nstop_sw, exp_nstop); end
      checks++; if (ndep_sw !== exp_ndep) begin errors++; $display("FAIL rnd_dep t=%0d got %b want %b", t, ndep_sw, exp_ndep); end
      checks++; if (nincp_sw !== exp_nincp) begin errors++; $display("FAIL rnd_incp t=%0d got %b want %b", t, nincp_sw, exp_nincp); end
      checks++; if (nsw !== exp_nsw) begin errors++; $display("FAIL rnd_nsw t=%0d got %h want %h", t, nsw, exp_nsw); end
    end
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_clean();
    test_dep_bounce();
    test_incp_repeat();
    test_run_gating();
    test_priority();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
